// File: rtl/uart_rx.sv
// UART receiver: 4x oversampled by baudtick, start/data/stop framing, one-word holding register.
// Optional parity check is compiled in with `define UART_RX_PARITY_EN.
`timescale 1ns/1ps

module uart_rx #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baudtick,
    input  logic                 rxd,
    input  logic                 rx_ready,
`ifdef UART_RX_PARITY_EN
    input  logic                 parity_odd,
    output logic                 parity_err,
`endif
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

    logic                 rxd_m, rxd_s;
    state_t               state_q, state_d;
    logic [1:0]           tick_q, tick_d;
    logic [2:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 frame_done;
    logic                 stop_bad;
    logic                 word_good;

    // rxd is asynchronous to clk; only rxd_s may feed decisions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_q, par_d;
    logic par_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) par_q <= 1'b0;
        else     par_q <= par_d;
    end
`endif

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        frame_done = 1'b0;
        stop_bad   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d      = par_q;
`endif
        if (baudtick) begin
            case (state_q)
                S_IDLE: begin
                    if (!rxd_s) begin
                        state_d = S_START;
                        tick_d  = '0;
                    end
                end
                S_START: begin
                    // Second tick after detection lands mid start bit.
                    if (tick_q == 2'd1) begin
                        if (rxd_s) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_DATA;
                            tick_d  = '0;
                            bit_d   = '0;
                        end
                    end else begin
                        tick_d = tick_q + 2'd1;
                    end
                end
                S_DATA: begin
                    tick_d = tick_q + 2'd1;
                    if (tick_q == 2'd3) begin
                        shreg_d = {rxd_s, shreg_q[DATA_BITS-1:1]};
                        if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    tick_d = tick_q + 2'd1;
                    if (tick_q == 2'd3) begin
                        par_d   = rxd_s;
                        state_d = S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    tick_d = tick_q + 2'd1;
                    if (tick_q == 2'd3) begin
                        state_d    = S_IDLE;
                        frame_done = rxd_s;
                        stop_bad   = !rxd_s;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

`ifdef UART_RX_PARITY_EN
    assign par_ok    = (par_q == (^shreg_q ^ parity_odd));
    assign word_good = frame_done && par_ok;
`else
    assign word_good = frame_done;
`endif

    // Holding register: a pop in the completion cycle frees room for the new word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err <= stop_bad;
            overrun   <= word_good && rx_valid && !rx_ready;
`ifdef UART_RX_PARITY_EN
            parity_err <= frame_done && !par_ok;
`endif
            if (word_good && (!rx_valid || rx_ready)) begin
                rx_data  <= shreg_q;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx (DATA_BITS=8, baudtick every 4 clk).
// Define UART_RX_PARITY_EN for both files to exercise the parity build.
`timescale 1ns/1ps

module tb_uart_rx;

    localparam int DATA_BITS = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 baudtick = 1'b0;
    logic                 rxd;
    logic                 rx_ready;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 overrun;
`ifdef UART_RX_PARITY_EN
    logic                 parity_odd;
    logic                 parity_err;
`endif

    int   checks = 0;
    int   errors = 0;
    int   n_ferr = 0;
    int   n_ovr  = 0;
    int   n_perr = 0;
    int   f0, o0, p0;
    logic valid_pre;

    uart_rx #(.DATA_BITS(DATA_BITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .baudtick  (baudtick),
        .rxd       (rxd),
        .rx_ready  (rx_ready),
`ifdef UART_RX_PARITY_EN
        .parity_odd(parity_odd),
        .parity_err(parity_err),
`endif
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (3) @(negedge clk);
            baudtick = 1'b1;
            @(negedge clk);
            baudtick = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (frame_err === 1'b1) n_ferr <= n_ferr + 1;
        if (overrun === 1'b1)   n_ovr  <= n_ovr + 1;
`ifdef UART_RX_PARITY_EN
        if (parity_err === 1'b1) n_perr <= n_perr + 1;
`endif
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns 1ns after the rising edge that ends a baudtick cycle.
    task automatic wait_tick();
        do @(posedge clk); while (!baudtick);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        repeat (4) wait_tick();
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) wait_tick();
    endtask

    // Drives a frame up to and including the stop-bit sampling tick; rdy is held
    // only during that tick cycle, and valid_pre records rx_valid just before it.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic rdy,
                              input logic par_flip);
        send_bit(1'b0);
        for (int i = 0; i < DATA_BITS; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(^d ^ parity_odd ^ par_flip);
`else
        if (par_flip) rxd = 1'b1;
`endif
        rxd = stop;
        repeat (2) wait_tick();
        repeat (4) @(negedge clk);
        rx_ready  = rdy;
        valid_pre = rx_valid;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
    endtask

    task automatic snap();
        f0 = n_ferr;
        o0 = n_ovr;
        p0 = n_perr;
    endtask

    initial begin
        rst      = 1'b1;
        rxd      = 1'b1;
        rx_ready = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_odd = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(rx_valid), 32'h0);
        check("rst_data", 32'(rx_data), 32'h0);
        check("rst_ferr", 32'(frame_err), 32'h0);
        check("rst_ovr", 32'(overrun), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        idle(4);

        // Bad stop bit: single frame_err pulse, nothing delivered.
        snap();
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        idle(3);
        check("ferr_3c_cnt", 32'(n_ferr - f0), 32'd1);
        check("ferr_3c_valid", 32'(rx_valid), 32'h0);
        check("ferr_3c_data", 32'(rx_data), 32'h0);
        check("ferr_3c_ovr", 32'(n_ovr - o0), 32'd0);

        // One-tick glitch is a false start.
        snap();
        rxd = 1'b0;
        wait_tick();
        idle(6);
        check("glitch_valid", 32'(rx_valid), 32'h0);
        check("glitch_ferr", 32'(n_ferr - f0), 32'd0);
        check("glitch_ovr", 32'(n_ovr - o0), 32'd0);

        // Clean frame, delivered exactly one clk after the stop sample.
        snap();
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        check("a5_valid_pre", 32'(valid_pre), 32'h0);
        check("a5_valid", 32'(rx_valid), 32'h1);
        check("a5_data", 32'(rx_data), 32'hA5);
        idle(2);
        check("a5_ferr", 32'(n_ferr - f0), 32'd0);
        check("a5_ovr", 32'(n_ovr - o0), 32'd0);

        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
        check("pop_valid", 32'(rx_valid), 32'h0);

        // Back-to-back frames, second start bit begins right after the stop sample.
        snap();
        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        check("ovr_first_data", 32'(rx_data), 32'h11);
        check("ovr_first_valid", 32'(rx_valid), 32'h1);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0);
        check("ovr_hold_data", 32'(rx_data), 32'h11);
        check("ovr_hold_valid", 32'(rx_valid), 32'h1);
        idle(2);
        check("ovr_cnt", 32'(n_ovr - o0), 32'd1);

        snap();
        send_frame(8'h22, 1'b1, 1'b1, 1'b0);
        check("popload_data", 32'(rx_data), 32'h22);
        check("popload_valid", 32'(rx_valid), 32'h1);
        idle(2);
        check("popload_ovr", 32'(n_ovr - o0), 32'd0);

        // Reset during data bit 4 of 0x5A, then a clean 0xC3.
        snap();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(((8'h5A >> i) & 8'h01) != 8'h00);
        rxd = 1'b1;
        repeat (2) wait_tick();
        rst = 1'b1;
        #2;
        check("midrst_valid", 32'(rx_valid), 32'h0);
        check("midrst_data", 32'(rx_data), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        idle(6);
        send_frame(8'hC3, 1'b1, 1'b0, 1'b0);
        check("c3_data", 32'(rx_data), 32'hC3);
        check("c3_valid", 32'(rx_valid), 32'h1);
        idle(2);
        check("c3_ferr", 32'(n_ferr - f0), 32'd0);
        check("c3_ovr", 32'(n_ovr - o0), 32'd0);

`ifdef UART_RX_PARITY_EN
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
        idle(2);
        snap();
        send_frame(8'h07, 1'b1, 1'b0, 1'b1);
        check("par_bad_valid", 32'(rx_valid), 32'h0);
        idle(2);
        check("par_bad_cnt", 32'(n_perr - p0), 32'd1);
        check("par_bad_ovr", 32'(n_ovr - o0), 32'd0);
        snap();
        send_frame(8'h07, 1'b1, 1'b0, 1'b0);
        check("par_ok_data", 32'(rx_data), 32'h07);
        check("par_ok_valid", 32'(rx_valid), 32'h1);
        idle(2);
        check("par_ok_cnt", 32'(n_perr - p0), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter: DATA_BITS, 8, number of data bits per frame, legal range 5-8.
REQ-002 SHALL have port: clk  input  1  single system clock, all state on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: baudtick  input  1  one-clk strobe at 4x the baud rate, from the baud generator.
REQ-005 SHALL have port: rxd  input  1  serial line, asynchronous to clk, idle high.
REQ-006 SHALL have port: rx_ready  input  1  consumer acknowledge; a cycle with rx_valid=1 and rx_ready=1 pops the held byte.
REQ-007 SHALL have port: rx_data  output  DATA_BITS  received data, LSB first on the line.
REQ-008 SHALL have port: rx_valid  output  1  rx_data holds an unread word.
REQ-009 SHALL have port: frame_err  output  1  one-clk pulse, stop bit sampled low.
REQ-010 SHALL have port: overrun  output  1  one-clk pulse, completed frame dropped because the holding register was full.

Function
REQ-011 SHALL pass rxd through a 2-flop synchronizer (reset value 1); all line decisions SHALL use the synchronized value rxd_s.
REQ-012 SHALL implement states IDLE, START, DATA, STOP, advancing only on cycles where baudtick=1.
REQ-013 IDLE: on baudtick with rxd_s=0 -> START, tick counter cleared.
REQ-014 START: count baudticks; on the 2nd tick after detection (mid start bit) sample rxd_s: 1 -> IDLE (false start, no output), 0 -> DATA, tick and bit counters cleared.
REQ-015 DATA: sample rxd_s every 4th baudtick (tick counter 3), shift in LSB first; after DATA_BITS samples -> STOP.
REQ-016 STOP: sample rxd_s on the 4th baudtick; 1 -> frame complete; 0 -> frame_err pulse, data discarded; both -> IDLE.
REQ-017 Completion SHALL be registered: rx_valid/rx_data update on the clk edge following the stop-bit sampling cycle.
REQ-018 rx_valid SHALL clear the cycle after a pop when no new frame completes in that cycle.
REQ-019 Completion with rx_valid=0, or with rx_valid=1 and rx_ready=1 in the same cycle: load new data, rx_valid=1, no overrun.
REQ-020 Completion with rx_valid=1 and rx_ready=0: keep old rx_data, pulse overrun, discard new word.
REQ-021 rx_data SHALL remain stable while rx_valid=1 and no load occurs.
REQ-022 A new start bit SHALL be detectable in the first baudtick after returning to IDLE.

Reset
REQ-023 rst=1 SHALL immediately force: state IDLE, counters 0, shift register 0, synchronizer 1, rx_data 0, rx_valid 0, frame_err 0, overrun 0 (and parity_err 0 when compiled in).
REQ-024 rst asserted mid-frame SHALL abandon the frame with no output pulse; reception resumes from IDLE after release.

Configuration
REQ-025 With macro UART_RX_PARITY_EN defined: input parity_odd (1-bit, 0=even, 1=odd) and output parity_err (one-clk pulse) SHALL exist; a PARITY state between DATA and STOP samples one parity bit at the 4th baudtick; mismatch SHALL pulse parity_err in the completion cycle and drop the word (no rx_valid, no overrun).
REQ-026 Without UART_RX_PARITY_EN: no parity_odd/parity_err ports, no PARITY state, frame = start + DATA_BITS + stop.

Verification (baudtick every 4 clk, DATA_BITS=8)
REQ-027 Frame 0xA5, rx_ready=0 -> rx_valid=1, rx_data=0xA5 one clk after stop sample; frame_err=0, overrun=0.
REQ-028 rxd low for 1 baudtick only -> state back to IDLE, rx_valid stays 0, no error pulses.
REQ-029 Frame 0x3C with stop bit 0 -> single frame_err pulse, rx_valid=0, rx_data=0x00.
REQ-030 Frames 0x11 then 0x22, rx_ready=0 -> rx_data=0x11, rx_valid=1, one overrun pulse; repeat with rx_ready=1 at 2nd completion -> rx_data=0x22, no overrun.
REQ-031 rst pulsed during DATA bit 4 of 0x5A, then frame 0xC3 -> only 0xC3 delivered, no error pulses.
REQ-032 UART_RX_PARITY_EN, parity_odd=0, 0x07 with parity bit 0 -> parity_err pulse, rx_valid=0; parity bit 1 -> rx_data=0x07, rx_valid=1.
